oled_cmd_fifo: RTL and testbench

OLED_CMD_FIFO -- requirements
Module: oled_cmd_fifo

---
 rtl/oled_pkg.sv | 19 +
 rtl/oled_fifo_ram.sv | 44 ++++
 rtl/oled_cmd_fifo.sv | 135 +++++++++++++
 tb/tb_oled_cmd_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and SSD1331 power-on command bytes for the OLED command FIFO.
// The preload table is used only when OLED_CMD_FIFO_PRELOAD_EN is defined.
package oled_pkg;

  localparam int unsigned INIT_LEN = 12;

  // Unlock, display off, remap, normal mode, mux ratio, master config,
  // deactivate scroll, display on.
  localparam logic [7:0] INIT_SEQ [INIT_LEN] = '{
    8'hFD, 8'h12, 8'hAE, 8'hA0, 8'h72, 8'hA4,
    8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'h2E, 8'hAF
  };

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/oled_fifo_ram.sv
// Single-clock FIFO storage: one write port, one asynchronous read port.
// With OLED_CMD_FIFO_PRELOAD_EN defined, reset loads INIT_SEQ as commands.
module oled_fifo_ram
  import oled_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  localparam int AW        = $clog2(DEPTH),
  localparam int W         = DATA_WIDTH + 1
) (
  input  logic          clk,
`ifdef OLED_CMD_FIFO_PRELOAD_EN
  input  logic          rst_n,
`endif
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

`ifdef OLED_CMD_FIFO_PRELOAD_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < INIT_LEN; i++) begin
        mem[AW'(i)] <= {1'b0, DATA_WIDTH'(INIT_SEQ[i])};
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end
`endif

  assign rdata = mem[raddr];

endmodule

// File: rtl/oled_cmd_fifo.sv
// First-word fall-through command/data FIFO for an SSD1331 OLED controller.
// Optional power-on command preload: define OLED_CMD_FIFO_PRELOAD_EN.
module oled_cmd_fifo
  import oled_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int AF_THRESH  = FIFO_DEPTH - 4,
  parameter int AE_THRESH  = 4,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_dc,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_dc,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int PW = $clog2(FIFO_DEPTH);

`ifdef OLED_CMD_FIFO_PRELOAD_EN
  if (INIT_LEN > FIFO_DEPTH) begin : g_init_len_check
    $error("oled_cmd_fifo: INIT_LEN exceeds FIFO_DEPTH");
  end
  localparam int unsigned RST_COUNT = INIT_LEN;
`else
  localparam int unsigned RST_COUNT = 0;
`endif
  localparam int unsigned RST_WPTR = RST_COUNT % FIFO_DEPTH;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wr_fire, rd_fire;
  logic [DATA_WIDTH:0] head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full         = (count_q == CW'(FIFO_DEPTH));
    empty        = (count_q == '0);
    almost_full  = (32'(count_q) >= 32'(AF_THRESH));
    almost_empty = (32'(count_q) <= 32'(AE_THRESH));
    wr_ready     = !full;
    rd_valid     = !empty;
    wr_fire      = wr_valid && wr_ready;
    rd_fire      = rd_valid && rd_ready;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // Clear first so a same-cycle error event wins over err_clr.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_valid && full) overflow_d = 1'b1;
    if (rd_ready && empty) underflow_d = 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_fire && !rd_fire) begin
        count_d = count_q + CW'(1);
      end else if (rd_fire && !wr_fire) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= PW'(RST_WPTR);
      rd_ptr_q    <= '0;
      count_q     <= CW'(RST_COUNT);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  oled_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_ram (
    .clk   (clk),
`ifdef OLED_CMD_FIFO_PRELOAD_EN
    .rst_n (rst_n),
`endif
    .we    (wr_fire && !flush),
    .waddr (wr_ptr_q),
    .wdata ({wr_dc, wr_data}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign rd_data   = head[DATA_WIDTH-1:0];
  assign rd_dc     = head[DATA_WIDTH];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_oled_cmd_fifo.sv
// Self-checking bench for oled_cmd_fifo (depth 16, AF 12, AE 4) against a
// queue-based reference model; honours OLED_CMD_FIFO_PRELOAD_EN.
module tb_oled_cmd_fifo;
  import oled_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, wr_valid, wr_dc, rd_ready, err_clr;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_valid, rd_dc;
  logic [DW-1:0] rd_data;
  logic [4:0]    count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  fifo_entry_t model_q[$];
  bit          m_ovf, m_unf;
  int          n_assert = 0;
  int          n_fail   = 0;

  oled_cmd_fifo #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .wr_dc        (wr_dc),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_dc        (rd_dc),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sz = model_q.size();
    chk("count", 32'(count), sz);
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(sz >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    chk("rd_valid", 32'(rd_valid), 32'(sz != 0));
    chk("wr_ready", 32'(wr_ready), 32'(sz != DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (sz != 0) begin
      chk("rd_data", 32'(rd_data), 32'(model_q[0].data));
      chk("rd_dc", 32'(rd_dc), 32'(model_q[0].dc));
    end
  endtask

  task automatic model_reset();
    model_q.delete();
`ifdef OLED_CMD_FIFO_PRELOAD_EN
    for (int i = 0; i < INIT_LEN; i++) model_q.push_back('{dc: 1'b0, data: INIT_SEQ[i]});
`endif
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock with the given inputs; reference model steps at the edge.
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic wdc,
                      input logic rr, input logic fl, input logic ec);
    int sz;
    bit do_rd, do_wr;
    wr_valid = wv; wr_data = wd; wr_dc = wdc;
    rd_ready = rr; flush = fl;  err_clr = ec;
    @(posedge clk);
    sz    = model_q.size();
    do_rd = rr && (sz > 0);
    do_wr = wv && (sz < DEPTH);
    m_ovf = (wv && sz == DEPTH) ? 1'b1 : (ec ? 1'b0 : m_ovf);
    m_unf = (rr && sz == 0)     ? 1'b1 : (ec ? 1'b0 : m_unf);
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) model_q.push_back('{dc: wdc, data: wd});
    end
    #1;
    check_all();
  endtask

  // Reset cycles with noisy inputs to show reset overrides everything.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      wr_valid = 1'b1; wr_data = 8'($urandom); wr_dc = 1'b1;
      rd_ready = 1'b1; flush = 1'b1; err_clr = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      check_all();
    end
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic dc);
    step(1'b1, d, dc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = '0;
    wr_dc = 1'b0; rd_ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    do_reset(2);

`ifdef OLED_CMD_FIFO_PRELOAD_EN
    // Preloaded sequence must drain in INIT_SEQ order as commands.
    chk("preload_count", 32'(count), INIT_LEN);
    for (int i = 0; i < INIT_LEN; i++) pop();
`endif

    // In-order fill and drain with alternating dc.
    for (int i = 0; i < DEPTH; i++) push(8'(i + 1), 1'(i % 2));
    chk("full_after_fill", 32'(full), 32'd1);
    for (int i = 0; i < DEPTH; i++) pop();
    chk("empty_after_drain", 32'(empty), 32'd1);

    // Overflow while full, err_clr versus set, then clear.
    for (int i = 0; i < DEPTH; i++) push(8'($urandom), 1'($urandom));
    for (int i = 0; i < 3; i++) push(8'hAA, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("overflow_cleared", 32'(overflow), 32'd0);

    // Full: write rejected while concurrent read proceeds.
    step(1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("full_read_write_count", 32'(count), DEPTH - 1);

    // Steady occupancy 8 with simultaneous traffic; pointers wrap.
    while (model_q.size() > 8) pop();
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
    chk("steady_count", 32'(count), 32'd8);

    // Single-entry latency, then underflow on empty.
    while (model_q.size() > 0) pop();
    push(8'h5A, 1'b0);
    chk("single_write_data", 32'(rd_data), 32'h5A);
    pop();
    pop();
    chk("underflow_set", 32'(underflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flush at count 10 discards the concurrent write.
    for (int i = 0; i < 10; i++) push(8'($urandom), 1'($urandom));
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'd0);

    // Randomized traffic, write-heavy then balanced, with a mid-run reset.
    for (int i = 0; i < 400; i++) begin
      int wp = (i < 150) ? 85 : 55;
      if (i == 250) begin
        do_reset(1);
      end else begin
        step(1'($urandom_range(0, 99) < wp), 8'($urandom), 1'($urandom),
             1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 3),
             1'($urandom_range(0, 99) < 5));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
